// File: rtl/otter_fetch_stage.sv
// Instruction-fetch stage of the pipelined OTTER RV32I core.
// Owns the PC, drives a 1-cycle-latency synchronous instruction memory and
// loads the IF/ID register. A skid register catches the word that arrives
// while decode is stalled. Any non-zero PC_SOURCE redirects fetch and squashes
// both the in-flight read and the IF/ID entry.
module otter_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  PC_SOURCE,
    input  logic [31:0] JALR_TARGET,
    input  logic [31:0] BRANCH_TARGET,
    input  logic [31:0] JAL_TARGET,
    input  logic        STALL,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_RD_EN,
    input  logic [31:0] IMEM_DATA,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC_PLUS4,
    output logic [31:0] IF_ID_INSTR,
    output logic        IF_ID_VALID
);

    // p0: address being issued to instruction memory
    logic [31:0] r_pc_p0;

    // p1: read in flight, plus skid register for stalled data
    logic [31:0] r_f_pc_p1;
    logic        r_f_vld_p1;
    logic [31:0] r_hold_instr_p1;
    logic        r_hold_vld_p1;

    // p2: IF/ID register
    logic [31:0] r_ifid_pc_p2;
    logic [31:0] r_ifid_pc4_p2;
    logic [31:0] r_ifid_instr_p2;
    logic        r_ifid_vld_p2;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_jalr_tgt;
    logic        w_capture;

    assign w_redirect = (PC_SOURCE != 2'd0);
    // jalr targets are halfword-aligned by the ISA: drop the low bit
    assign w_jalr_tgt = JALR_TARGET & ~32'h0000_0001;
    // Only the first stall cycle with a live read has the word on the bus
    assign w_capture  = STALL && r_f_vld_p1 && !r_hold_vld_p1;

    assign IMEM_ADDR      = r_pc_p0;
    assign IMEM_RD_EN     = !STALL && !RST;
    assign IF_ID_PC       = r_ifid_pc_p2;
    assign IF_ID_PC_PLUS4 = r_ifid_pc4_p2;
    assign IF_ID_INSTR    = r_ifid_instr_p2;
    assign IF_ID_VALID    = r_ifid_vld_p2;

    // Select the redirect target from the branch condition generator
    always_comb begin
        w_target = 32'h0000_0000;
        case (PC_SOURCE)
            2'd1:    w_target = w_jalr_tgt;
            2'd2:    w_target = BRANCH_TARGET;
            2'd3:    w_target = JAL_TARGET;
            default: w_target = 32'h0000_0000;
        endcase
    end

    // PC, valid bits and IF/ID register: redirect beats stall, stall freezes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc_p0         <= RESET_VECTOR;
            r_f_vld_p1      <= 1'b0;
            r_hold_vld_p1   <= 1'b0;
            r_ifid_pc_p2    <= 32'h0000_0000;
            r_ifid_pc4_p2   <= 32'h0000_0000;
            r_ifid_instr_p2 <= 32'h0000_0000;
            r_ifid_vld_p2   <= 1'b0;
        end else if (w_redirect) begin
            r_pc_p0       <= w_target;
            r_f_vld_p1    <= 1'b0;
            r_hold_vld_p1 <= 1'b0;
            r_ifid_vld_p2 <= 1'b0;
        end else if (!STALL) begin
            r_pc_p0         <= r_pc_p0 + 32'd4;
            r_f_vld_p1      <= 1'b1;
            r_ifid_pc_p2    <= r_f_pc_p1;
            r_ifid_pc4_p2   <= r_f_pc_p1 + 32'd4;
            r_ifid_instr_p2 <= r_hold_vld_p1 ? r_hold_instr_p1 : IMEM_DATA;
            r_ifid_vld_p2   <= r_f_vld_p1;
            r_hold_vld_p1   <= 1'b0;
        end else if (w_capture) begin
            r_hold_vld_p1 <= 1'b1;
        end
    end

    // In-flight address and skid data; qualified by their valid bits
    always_ff @(posedge CLK) begin
        if (!w_redirect) begin
            if (!STALL) begin
                r_f_pc_p1 <= r_pc_p0;
            end else if (w_capture) begin
                r_hold_instr_p1 <= IMEM_DATA;
            end
        end
    end

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Bench for otter_fetch_stage: synchronous IMEM model returning addr+0x100,
// scoreboard of the PCs decode must accept, plus cycle-exact spot checks.
module tb_otter_fetch_stage;

    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] OFS  = 32'h0000_0100;
    localparam logic [31:0] IDLE = 32'hDEAD_BEEF;

    logic        CLK;
    logic        RST;
    logic [1:0]  PC_SOURCE;
    logic [31:0] JALR_TARGET;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] JAL_TARGET;
    logic        STALL;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RD_EN;
    logic [31:0] IMEM_DATA;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PC_PLUS4;
    logic [31:0] IF_ID_INSTR;
    logic        IF_ID_VALID;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    otter_fetch_stage #(.RESET_VECTOR(RV)) dut (
        .CLK(CLK),
        .RST(RST),
        .PC_SOURCE(PC_SOURCE),
        .JALR_TARGET(JALR_TARGET),
        .BRANCH_TARGET(BRANCH_TARGET),
        .JAL_TARGET(JAL_TARGET),
        .STALL(STALL),
        .IMEM_ADDR(IMEM_ADDR),
        .IMEM_RD_EN(IMEM_RD_EN),
        .IMEM_DATA(IMEM_DATA),
        .IF_ID_PC(IF_ID_PC),
        .IF_ID_PC_PLUS4(IF_ID_PC_PLUS4),
        .IF_ID_INSTR(IF_ID_INSTR),
        .IF_ID_VALID(IF_ID_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous instruction memory, 1-cycle latency; junk when not read
    always @(posedge CLK) begin
        IMEM_DATA <= IMEM_RD_EN ? (IMEM_ADDR + OFS) : IDLE;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then drive the cycle's inputs
    task automatic cyc(input logic stall, input logic [1:0] psrc);
        @(posedge CLK);
        #1;
        STALL     = stall;
        PC_SOURCE = psrc;
    endtask

    // Decode accepts an instruction when valid, not stalled and not squashed
    always @(negedge CLK) begin
        if (IF_ID_VALID && !STALL && PC_SOURCE == 2'd0 && !RST) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_accept", IF_ID_PC, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] p;
                p = exp_q.pop_front();
                chk("sb_pc", IF_ID_PC, p);
                chk("sb_pc4", IF_ID_PC_PLUS4, p + 32'd4);
                chk("sb_instr", IF_ID_INSTR, p + OFS);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; STALL = 1'b0; PC_SOURCE = 2'd0;
        JALR_TARGET = 32'h0; BRANCH_TARGET = 32'h0; JAL_TARGET = 32'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_valid", {31'h0, IF_ID_VALID}, 32'h0);
        chk("rst_pc", IF_ID_PC, 32'h0);
        chk("rst_pc4", IF_ID_PC_PLUS4, 32'h0);
        chk("rst_instr", IF_ID_INSTR, 32'h0);
        chk("rst_rden", {31'h0, IMEM_RD_EN}, 32'h0);
        chk("rst_addr", IMEM_ADDR, RV);

        // Sequential fetch, then a 3-cycle stall with the 0x8 read in flight
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        @(posedge CLK); #1; RST = 1'b0;                 // cycle 0
        @(negedge CLK);
        chk("c0_addr", IMEM_ADDR, RV);
        chk("c0_rden", {31'h0, IMEM_RD_EN}, 32'h1);
        chk("c0_valid", {31'h0, IF_ID_VALID}, 32'h0);
        cyc(1'b0, 2'd0);                                // cycle 1
        @(negedge CLK);
        chk("c1_valid", {31'h0, IF_ID_VALID}, 32'h0);
        cyc(1'b0, 2'd0);                                // cycle 2
        @(negedge CLK);
        chk("c2_valid", {31'h0, IF_ID_VALID}, 32'h1);
        for (int i = 0; i < 3; i++) begin               // cycles 3..5
            cyc(1'b1, 2'd0);
            @(negedge CLK);
            chk("stall_ifid_pc", IF_ID_PC, 32'h4);
            chk("stall_rden", {31'h0, IMEM_RD_EN}, 32'h0);
            chk("stall_addr", IMEM_ADDR, 32'hC);
        end
        cyc(1'b0, 2'd0);                                // cycle 6
        cyc(1'b0, 2'd0);                                // cycle 7
        cyc(1'b0, 2'd0);                                // cycle 8

        // Branch redirect while 0x10 sits in IF/ID
        exp_q.push_back(32'h40);
        BRANCH_TARGET = 32'h40;
        cyc(1'b0, 2'd2);                                // cycle 9
        @(negedge CLK);
        chk("br_ifid_pc", IF_ID_PC, 32'h10);
        cyc(1'b0, 2'd0);                                // cycle 10
        @(negedge CLK);
        chk("br_addr", IMEM_ADDR, 32'h40);
        chk("br_bubble0", {31'h0, IF_ID_VALID}, 32'h0);
        cyc(1'b0, 2'd0);                                // cycle 11
        @(negedge CLK);
        chk("br_bubble1", {31'h0, IF_ID_VALID}, 32'h0);
        cyc(1'b0, 2'd0);                                // cycle 12

        // jalr redirect together with stall, skid register holding 0x48
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        cyc(1'b1, 2'd0);                                // cycle 13
        JALR_TARGET = 32'h101;
        cyc(1'b1, 2'd1);                                // cycle 14
        cyc(1'b0, 2'd0);                                // cycle 15
        @(negedge CLK);
        chk("jalr_addr", IMEM_ADDR, 32'h100);
        chk("jalr_bubble0", {31'h0, IF_ID_VALID}, 32'h0);
        cyc(1'b0, 2'd0);                                // cycle 16
        @(negedge CLK);
        chk("jalr_bubble1", {31'h0, IF_ID_VALID}, 32'h0);
        cyc(1'b0, 2'd0);                                // cycle 17
        cyc(1'b0, 2'd0);                                // cycle 18

        // jal to the top of the address space, PC wraps to 0
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        JAL_TARGET = 32'hFFFF_FFFC;
        cyc(1'b0, 2'd3);                                // cycle 19
        cyc(1'b0, 2'd0);                                // cycle 20
        @(negedge CLK);
        chk("jal_addr", IMEM_ADDR, 32'hFFFF_FFFC);
        cyc(1'b0, 2'd0);                                // cycle 21
        cyc(1'b0, 2'd0);                                // cycle 22
        @(negedge CLK);
        chk("wrap_pc4", IF_ID_PC_PLUS4, 32'h0);
        cyc(1'b0, 2'd0);                                // cycle 23

        // Async reset mid-stall with the skid register full
        cyc(1'b1, 2'd0);                                // cycle 24
        cyc(1'b1, 2'd0);                                // cycle 25
        #2;
        RST = 1'b1;
        #1;
        chk("arst_valid", {31'h0, IF_ID_VALID}, 32'h0);
        chk("arst_pc", IF_ID_PC, 32'h0);
        chk("arst_pc4", IF_ID_PC_PLUS4, 32'h0);
        chk("arst_instr", IF_ID_INSTR, 32'h0);
        chk("arst_addr", IMEM_ADDR, RV);
        chk("arst_rden", {31'h0, IMEM_RD_EN}, 32'h0);
        STALL = 1'b0;
        repeat (2) @(posedge CLK);

        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        #1; RST = 1'b0;                                 // cycle 0
        @(negedge CLK);
        chk("rst2_addr", IMEM_ADDR, RV);
        cyc(1'b0, 2'd0);                                // cycle 1
        cyc(1'b0, 2'd0);                                // cycle 2
        cyc(1'b0, 2'd0);                                // cycle 3
        cyc(1'b0, 2'd0);                                // cycle 4
        @(negedge CLK);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_fetch_stage.md
Name: otter_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined OTTER RV32I core, directly downstream of the branch condition generator.
- Consumes the generator's 2-bit pcSource and the three target addresses from execute, and owns the PC register.
- Drives a synchronous instruction memory with a 1-cycle read latency, and loads the IF/ID pipeline register.
- Handles decode stalls without losing an in-flight instruction, and squashes wrong-path fetches on redirect.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- PC_SOURCE  input  2  from branch condition generator:
  - 0 = PC+4
  - 1 = jalr
  - 2 = branch
  - 3 = jal
- JALR_TARGET  input  32  jalr target from execute.
- BRANCH_TARGET  input  32  branch target from execute.
- JAL_TARGET  input  32  jal target from execute.
- STALL  input  1  hazard unit: hold fetch and IF/ID.
- IMEM_ADDR  output  32  fetch address (= PC register, combinational).
- IMEM_RD_EN  output  1  read strobe.
- IMEM_DATA  input  32  instruction word, valid exactly 1 cycle after an accepted read.
- IF_ID_PC  output  32  registered PC of the decode instruction.
- IF_ID_PC_PLUS4  output  32  registered IF_ID_PC+4.
- IF_ID_INSTR  output  32  registered instruction word.
- IF_ID_VALID  output  1  IF/ID holds a live instruction.

Behaviour:
- Internal state:
  - PC: next address to issue.
  - F_PC / F_VALID: address and liveness of the read whose data arrives this cycle.
  - HOLD_INSTR / HOLD_VALID: skid register.
- Reset (asynchronous, any cycle, including mid-stall or mid-redirect):
  - PC = RESET_VECTOR.
  - F_VALID = 0, HOLD_VALID = 0, IF_ID_VALID = 0.
  - IF_ID_PC, IF_ID_PC_PLUS4 and IF_ID_INSTR = 0.
  - IMEM_RD_EN = 0 while RST is high.
- IMEM_RD_EN = !STALL && !RST. IMEM_ADDR = PC at all times.
- Redirect is defined as PC_SOURCE != 0. A redirect has priority over STALL.
- Redirect cycle (regardless of STALL):
  - PC <= selected target. The jalr target has bit 0 cleared; all targets are used unmodified otherwise.
  - F_VALID <= 0, HOLD_VALID <= 0, IF_ID_VALID <= 0.
  - Both the in-flight fetch and the IF/ID entry are squashed.
  - The fetch at the target is issued in the following cycle.
- Normal cycle (no redirect, STALL = 0):
  - PC <= PC+4, 32-bit wrap: 32'hFFFF_FFFC -> 32'h0000_0000.
  - F_PC <= PC, F_VALID <= 1.
  - IF_ID_PC <= F_PC and IF_ID_PC_PLUS4 <= F_PC+4 (wrapping).
  - IF_ID_INSTR <= HOLD_VALID ? HOLD_INSTR : IMEM_DATA.
  - IF_ID_VALID <= F_VALID.
  - HOLD_VALID <= 0.
- Stall cycle (no redirect, STALL = 1):
  - PC, F_PC, F_VALID and all IF_ID_* outputs hold.
  - If F_VALID && !HOLD_VALID: HOLD_INSTR <= IMEM_DATA, HOLD_VALID <= 1. This is the only cycle that data is presented.
  - Further stall cycles leave HOLD_INSTR unchanged.
- Latency:
  - After RST falls, RESET_VECTOR is issued in cycle 0 and IF_ID_VALID = 1 from cycle 2.
  - Redirect penalty: the target instruction reaches IF/ID 2 cycles after the redirect edge.
- There is no output change other than those listed. No instruction is ever duplicated or dropped across any stall length.

Test Plan:
- Reset, RESET_VECTOR=0, IMEM returns addr+0x100, STALL=0, PC_SOURCE=0 -> IF_ID_PC 0,4,8,... from cycle 2; IF_ID_INSTR = IF_ID_PC+0x100; IF_ID_VALID=1 continuously.
- STALL high for 3 cycles while F_VALID=1 for PC 0x8 -> IF/ID holds 0x4 throughout; after release, IF_ID_PC=0x8 with the correct word (from HOLD); then 0xC; no duplicates, no gaps.
- PC_SOURCE=2, BRANCH_TARGET=0x40 while IF_ID_PC=0x10 -> IF_ID_VALID=0 for 2 cycles; next valid IF_ID_PC=0x40, then 0x44.
- PC_SOURCE=1, JALR_TARGET=0x101 simultaneous with STALL=1 -> redirect wins; IMEM_ADDR=0x100 next cycle; HOLD discarded; first valid IF_ID_PC=0x100.
- PC forced near top via PC_SOURCE=3, JAL_TARGET=0xFFFF_FFFC -> IF_ID_PC=0xFFFF_FFFC, IF_ID_PC_PLUS4=0, next IF_ID_PC=0x0.
- RST asserted mid-stall with HOLD_VALID=1 -> all outputs are at reset values immediately (async); after release, fetch restarts at RESET_VECTOR with no stale HOLD word.
